// File: rtl/ife_pkg.sv
// Shared types, default parameters and helpers for the IFE core scheduler.
package ife_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PAR_ISSUE,
    WAIT_CMT,
    SER_ISSUE
  } sched_state_e;

  localparam int unsigned DEF_BLOCK_ID_WIDTH  = 8;
  localparam int unsigned DEF_NUM_CORES       = 3;
  localparam int unsigned DEF_CORES_PER_BLOCK = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 255;
  localparam int unsigned DEF_CNT_WIDTH       = 16;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += {31'b0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/ife_core_picker.sv
// Combinational selector of the lowest-indexed idle cores for a parallel block.
module ife_core_picker
  import ife_pkg::*;
#(
  parameter int unsigned NUM_CORES       = DEF_NUM_CORES,
  parameter int unsigned CORES_PER_BLOCK = DEF_CORES_PER_BLOCK
) (
  input  logic [NUM_CORES-1:0] i_core_busy,
  output logic [NUM_CORES-1:0] o_mask,
  output logic                 o_enough
);

  logic [NUM_CORES-1:0] w_idle;

  assign w_idle   = ~i_core_busy;
  assign o_enough = popcount(32'(w_idle)) >= CORES_PER_BLOCK;

  always_comb begin
    int unsigned w_taken;
    w_taken = 0;
    o_mask  = '0;
    for (int i = 0; i < int'(NUM_CORES); i++) begin
      if (w_idle[i] && (w_taken < CORES_PER_BLOCK)) begin
        o_mask[i] = 1'b1;
        w_taken++;
      end
    end
  end

endmodule

// File: rtl/ife_core_scheduler.sv
// Routes one block at a time to the parallel cores or the serial path, and
// re-issues it serially on a failed commit or a watchdog timeout.
module ife_core_scheduler
  import ife_pkg::*;
#(
  parameter int unsigned BLOCK_ID_WIDTH  = DEF_BLOCK_ID_WIDTH,
  parameter int unsigned NUM_CORES       = DEF_NUM_CORES,
  parameter int unsigned CORES_PER_BLOCK = DEF_CORES_PER_BLOCK,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned CNT_WIDTH       = DEF_CNT_WIDTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_blk_valid,
  output logic                      o_blk_ready,
  input  logic [BLOCK_ID_WIDTH-1:0] i_blk_id,
  input  logic                      i_blk_safe,
  input  logic [NUM_CORES-1:0]      i_core_busy,
  output logic                      o_par_valid,
  input  logic                      i_par_ready,
  output logic [BLOCK_ID_WIDTH-1:0] o_par_block_id,
  output logic [NUM_CORES-1:0]      o_par_core_mask,
  output logic                      o_ser_valid,
  input  logic                      i_ser_ready,
  output logic [BLOCK_ID_WIDTH-1:0] o_ser_block_id,
  output logic                      o_ser_reexec,
  input  logic                      i_cmt_valid,
  input  logic [BLOCK_ID_WIDTH-1:0] i_cmt_block_id,
  input  logic                      i_cmt_ok,
  output logic                      o_timeout_pulse,
  output logic [CNT_WIDTH-1:0]      o_par_cnt,
  output logic [CNT_WIDTH-1:0]      o_fallback_cnt
);

  localparam int unsigned          TW         = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0]        TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

  sched_state_e              r_state;
  logic [BLOCK_ID_WIDTH-1:0] r_id;
  logic [NUM_CORES-1:0]      r_mask;
  logic                      r_par_valid;
  logic                      r_ser_valid;
  logic                      r_reexec;
  logic                      r_pulse;
  logic [TW-1:0]             r_timer;
  logic [CNT_WIDTH-1:0]      r_par_cnt;
  logic [CNT_WIDTH-1:0]      r_fb_cnt;

  logic [NUM_CORES-1:0] w_pick_mask;
  logic                 w_enough;
  logic                 w_cmt_match;
  logic                 w_expire;

  ife_core_picker #(
    .NUM_CORES      (NUM_CORES),
    .CORES_PER_BLOCK(CORES_PER_BLOCK)
  ) u_picker (
    .i_core_busy(i_core_busy),
    .o_mask     (w_pick_mask),
    .o_enough   (w_enough)
  );

  assign w_cmt_match = i_cmt_valid && (i_cmt_block_id == r_id);
  assign w_expire    = (r_timer == TIMER_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_id        <= '0;
      r_mask      <= '0;
      r_par_valid <= 1'b0;
      r_ser_valid <= 1'b0;
      r_reexec    <= 1'b0;
      r_pulse     <= 1'b0;
      r_timer     <= '0;
      r_par_cnt   <= '0;
      r_fb_cnt    <= '0;
    end else begin
      r_pulse <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_blk_valid) begin
            r_id <= i_blk_id;
            if (i_blk_safe && w_enough) begin
              r_mask      <= w_pick_mask;
              r_par_valid <= 1'b1;
              r_state     <= PAR_ISSUE;
            end else begin
              r_reexec    <= 1'b0;
              r_ser_valid <= 1'b1;
              r_state     <= SER_ISSUE;
            end
          end
        end
        PAR_ISSUE: begin
          if (i_par_ready) begin
            r_par_valid <= 1'b0;
            r_timer     <= '0;
            r_state     <= WAIT_CMT;
          end
        end
        WAIT_CMT: begin
          r_timer <= r_timer + 1'b1;
          // A matching verdict takes priority over an expiring watchdog.
          if (w_cmt_match && i_cmt_ok) begin
            r_par_cnt <= (r_par_cnt == CNT_MAX) ? r_par_cnt : r_par_cnt + 1'b1;
            r_state   <= IDLE;
          end else if (w_cmt_match || w_expire) begin
            r_pulse     <= !w_cmt_match;
            r_fb_cnt    <= (r_fb_cnt == CNT_MAX) ? r_fb_cnt : r_fb_cnt + 1'b1;
            r_reexec    <= 1'b1;
            r_ser_valid <= 1'b1;
            r_state     <= SER_ISSUE;
          end
        end
        SER_ISSUE: begin
          if (i_ser_ready) begin
            r_ser_valid <= 1'b0;
            r_reexec    <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_blk_ready     = (r_state == IDLE);
  assign o_par_valid     = r_par_valid;
  assign o_par_block_id  = r_id;
  assign o_par_core_mask = r_mask;
  assign o_ser_valid     = r_ser_valid;
  assign o_ser_block_id  = r_id;
  assign o_ser_reexec    = r_reexec;
  assign o_timeout_pulse = r_pulse;
  assign o_par_cnt       = r_par_cnt;
  assign o_fallback_cnt  = r_fb_cnt;

endmodule

// File: tb/tb_ife_core_scheduler.sv
// Self-checking bench: vector table, directed corner sequences and random traffic vs a model.
module tb_ife_core_scheduler;

  localparam int unsigned BW  = 8;
  localparam int unsigned NC  = 3;
  localparam int unsigned CPB = 2;
  localparam int unsigned TO  = 4;
  localparam int unsigned CW  = 3;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          blk_valid, blk_safe, par_ready, ser_ready, cmt_valid, cmt_ok;
  logic [BW-1:0] blk_id, cmt_id;
  logic [NC-1:0] core_busy;

  logic          blk_ready, par_valid, ser_valid, ser_reexec, timeout_pulse;
  logic [BW-1:0] par_block_id, ser_block_id;
  logic [NC-1:0] par_core_mask;
  logic [CW-1:0] par_cnt, fallback_cnt;

  always #5 clk = ~clk;

  ife_core_scheduler #(
    .BLOCK_ID_WIDTH (BW),
    .NUM_CORES      (NC),
    .CORES_PER_BLOCK(CPB),
    .TIMEOUT_CYCLES (TO),
    .CNT_WIDTH      (CW)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_blk_valid    (blk_valid),
    .o_blk_ready    (blk_ready),
    .i_blk_id       (blk_id),
    .i_blk_safe     (blk_safe),
    .i_core_busy    (core_busy),
    .o_par_valid    (par_valid),
    .i_par_ready    (par_ready),
    .o_par_block_id (par_block_id),
    .o_par_core_mask(par_core_mask),
    .o_ser_valid    (ser_valid),
    .i_ser_ready    (ser_ready),
    .o_ser_block_id (ser_block_id),
    .o_ser_reexec   (ser_reexec),
    .i_cmt_valid    (cmt_valid),
    .i_cmt_block_id (cmt_id),
    .i_cmt_ok       (cmt_ok),
    .o_timeout_pulse(timeout_pulse),
    .o_par_cnt      (par_cnt),
    .o_fallback_cnt (fallback_cnt)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: where the current block lives and what has been counted.
  localparam int MIdle = 0, MPar = 1, MWait = 2, MSer = 3;
  int          m_where;
  logic [BW-1:0] m_id;
  logic [NC-1:0] m_mask;
  bit          m_reexec, m_pulse;
  int          m_waited, m_par, m_fb;

  task automatic model_fallback(input bit timed_out);
    m_pulse  = timed_out;
    m_fb     = (m_fb < CMAX) ? m_fb + 1 : m_fb;
    m_reexec = 1'b1;
    m_where  = MSer;
  endtask

  task automatic model_step();
    int idle_q[$];
    m_pulse = 1'b0;
    if (rst) begin
      m_where = MIdle; m_id = '0; m_mask = '0; m_reexec = 1'b0;
      m_waited = 0; m_par = 0; m_fb = 0;
      return;
    end
    case (m_where)
      MIdle: if (blk_valid) begin
        m_id = blk_id;
        for (int i = 0; i < int'(NC); i++) if (!core_busy[i]) idle_q.push_back(i);
        if (blk_safe && idle_q.size() >= int'(CPB)) begin
          m_mask = '0;
          for (int k = 0; k < int'(CPB); k++) m_mask[idle_q[k]] = 1'b1;
          m_where = MPar;
        end else begin
          m_reexec = 1'b0;
          m_where  = MSer;
        end
      end
      MPar: if (par_ready) begin
        m_where  = MWait;
        m_waited = 0;
      end
      MWait: begin
        m_waited++;
        if (cmt_valid && cmt_id == m_id) begin
          if (cmt_ok) begin
            m_par   = (m_par < CMAX) ? m_par + 1 : m_par;
            m_where = MIdle;
          end else begin
            model_fallback(1'b0);
          end
        end else if (m_waited == int'(TO)) begin
          model_fallback(1'b1);
        end
      end
      MSer: if (ser_ready) begin
        m_reexec = 1'b0;
        m_where  = MIdle;
      end
      default: m_where = MIdle;
    endcase
  endtask

  task automatic compare_model();
    chk("m_blk_ready", blk_ready, m_where == MIdle);
    chk("m_par_valid", par_valid, m_where == MPar);
    chk("m_ser_valid", ser_valid, m_where == MSer);
    chk("m_timeout_pulse", timeout_pulse, m_pulse);
    chk("m_par_cnt", par_cnt, m_par);
    chk("m_fallback_cnt", fallback_cnt, m_fb);
    if (m_where == MPar) begin
      chk("m_par_block_id", par_block_id, m_id);
      chk("m_par_core_mask", par_core_mask, m_mask);
    end
    if (m_where == MSer) begin
      chk("m_ser_block_id", ser_block_id, m_id);
      chk("m_ser_reexec", ser_reexec, m_reexec);
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic quiet_inputs();
    rst = 1'b0; blk_valid = 1'b0; blk_id = '0; blk_safe = 1'b0; core_busy = '0;
    par_ready = 1'b0; ser_ready = 1'b0; cmt_valid = 1'b0; cmt_id = '0; cmt_ok = 1'b0;
  endtask

  task automatic accept(input logic [BW-1:0] id, input bit safe, input logic [NC-1:0] busy);
    blk_valid = 1'b1; blk_id = id; blk_safe = safe; core_busy = busy;
    cycle();
    blk_valid = 1'b0; core_busy = '0;
  endtask

  task automatic commit(input logic [BW-1:0] id, input bit ok);
    cmt_valid = 1'b1; cmt_id = id; cmt_ok = ok;
    cycle();
    cmt_valid = 1'b0;
  endtask

  task automatic par_handshake();
    par_ready = 1'b1;
    cycle();
    par_ready = 1'b0;
  endtask

  task automatic ser_handshake();
    ser_ready = 1'b1;
    cycle();
    ser_ready = 1'b0;
  endtask

  typedef struct {
    logic [NC-1:0] busy;
    bit            safe;
    bit            exp_par;
    logic [NC-1:0] exp_mask;
  } vec_t;

  vec_t vt[8];

  initial begin
    vt[0] = '{3'b000, 1'b1, 1'b1, 3'b011};
    vt[1] = '{3'b001, 1'b1, 1'b1, 3'b110};
    vt[2] = '{3'b010, 1'b1, 1'b1, 3'b101};
    vt[3] = '{3'b100, 1'b1, 1'b1, 3'b011};
    vt[4] = '{3'b011, 1'b1, 1'b0, 3'b000};
    vt[5] = '{3'b110, 1'b1, 1'b0, 3'b000};
    vt[6] = '{3'b111, 1'b1, 1'b0, 3'b000};
    vt[7] = '{3'b000, 1'b0, 1'b0, 3'b000};

    quiet_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("reset_blk_ready", blk_ready, 1);
    chk("reset_par_valid", par_valid, 0);
    chk("reset_ser_valid", ser_valid, 0);
    chk("reset_par_cnt", par_cnt, 0);
    chk("reset_fallback_cnt", fallback_cnt, 0);

    // Basic parallel block with an ok verdict.
    accept(8'h05, 1'b1, 3'b001);
    chk("par_basic_valid", par_valid, 1);
    chk("par_basic_mask", par_core_mask, 3'b110);
    chk("par_basic_id", par_block_id, 8'h05);
    chk("par_basic_blk_ready", blk_ready, 0);
    par_handshake();
    chk("par_basic_dropped", par_valid, 0);
    commit(8'h05, 1'b1);
    chk("par_basic_cnt", par_cnt, 1);
    chk("par_basic_idle", blk_ready, 1);

    // Path selection table.
    for (int i = 0; i < 8; i++) begin
      accept(8'h40 + 8'(i), vt[i].safe, vt[i].busy);
      chk("tbl_par_valid", par_valid, vt[i].exp_par);
      chk("tbl_ser_valid", ser_valid, !vt[i].exp_par);
      if (vt[i].exp_par) begin
        chk("tbl_mask", par_core_mask, vt[i].exp_mask);
        chk("tbl_par_id", par_block_id, 8'h40 + 8'(i));
        par_handshake();
        commit(8'h40 + 8'(i), 1'b1);
      end else begin
        chk("tbl_ser_id", ser_block_id, 8'h40 + 8'(i));
        chk("tbl_ser_reexec", ser_reexec, 0);
        ser_handshake();
      end
      chk("tbl_back_idle", blk_ready, 1);
    end

    // Fail verdict, with a foreign verdict ignored first; then serial backpressure.
    accept(8'h22, 1'b1, 3'b000);
    par_handshake();
    commit(8'h23, 1'b0);
    chk("foreign_cmt_ignored", ser_valid, 0);
    chk("foreign_cmt_busy", blk_ready, 0);
    commit(8'h22, 1'b0);
    chk("fail_ser_valid", ser_valid, 1);
    chk("fail_reexec", ser_reexec, 1);
    chk("fail_ser_id", ser_block_id, 8'h22);
    chk("fail_fb_cnt", fallback_cnt, 1);
    chk("fail_no_pulse", timeout_pulse, 0);
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("ser_bp_valid", ser_valid, 1);
      chk("ser_bp_id", ser_block_id, 8'h22);
      chk("ser_bp_reexec", ser_reexec, 1);
      chk("ser_bp_blk_ready", blk_ready, 0);
    end
    ser_handshake();
    chk("ser_done_valid", ser_valid, 0);
    chk("ser_done_reexec", ser_reexec, 0);

    // Watchdog expiry: the pulse lands on the 4th cycle after entering WAIT_CMT.
    accept(8'h30, 1'b1, 3'b000);
    par_handshake();
    for (int k = 1; k <= int'(TO); k++) begin
      cycle();
      chk("to_pulse_timing", timeout_pulse, k == int'(TO));
    end
    chk("to_reexec", ser_reexec, 1);
    chk("to_ser_id", ser_block_id, 8'h30);
    chk("to_fb_cnt", fallback_cnt, 2);
    cycle();
    chk("to_pulse_one_cycle", timeout_pulse, 0);
    ser_handshake();

    // Matching ok verdict on the expiry cycle wins over the watchdog.
    accept(8'h31, 1'b1, 3'b000);
    par_handshake();
    for (int k = 1; k < int'(TO); k++) cycle();
    commit(8'h31, 1'b1);
    chk("race_no_pulse", timeout_pulse, 0);
    chk("race_idle", blk_ready, 1);
    chk("race_par_cnt", par_cnt, 6);
    chk("race_fb_cnt", fallback_cnt, 2);

    // Parallel backpressure: mask must ignore later core_busy changes.
    accept(8'h50, 1'b1, 3'b100);
    for (int k = 0; k < 5; k++) begin
      core_busy = NC'($urandom_range(0, 7));
      cycle();
      chk("par_bp_valid", par_valid, 1);
      chk("par_bp_id", par_block_id, 8'h50);
      chk("par_bp_mask", par_core_mask, 3'b011);
      chk("par_bp_blk_ready", blk_ready, 0);
    end
    par_handshake();

    // Reset while waiting for a verdict; a late verdict must not count.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_wait_par_valid", par_valid, 0);
    chk("rst_wait_ser_valid", ser_valid, 0);
    chk("rst_wait_blk_ready", blk_ready, 1);
    chk("rst_wait_par_cnt", par_cnt, 0);
    chk("rst_wait_fb_cnt", fallback_cnt, 0);
    commit(8'h50, 1'b1);
    chk("rst_late_cmt", par_cnt, 0);

    // Reset during a serial request.
    accept(8'h60, 1'b0, 3'b000);
    chk("pre_rst_ser_valid", ser_valid, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_ser_reexec", ser_reexec, 0);
    chk("rst_ser_blk_ready", blk_ready, 1);
    chk("rst_ser_pulse", timeout_pulse, 0);

    // Counter saturation.
    for (int i = 0; i < CMAX + 2; i++) begin
      accept(8'h70 + 8'(i), 1'b1, 3'b000);
      par_handshake();
      commit(8'h70 + 8'(i), 1'b1);
      if (i == CMAX - 1) chk("sat_reach_max", par_cnt, CMAX);
    end
    chk("sat_hold_max", par_cnt, CMAX);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      blk_valid = $urandom_range(0, 1) == 1;
      blk_id    = 8'h10 + 8'($urandom_range(0, 3));
      blk_safe  = $urandom_range(0, 3) != 0;
      core_busy = NC'($urandom_range(0, 7));
      par_ready = $urandom_range(0, 9) < 6;
      ser_ready = $urandom_range(0, 9) < 6;
      cmt_valid = $urandom_range(0, 9) < 3;
      cmt_id    = ($urandom_range(0, 2) == 0) ? 8'h10 + 8'($urandom_range(0, 3)) : m_id;
      cmt_ok    = $urandom_range(0, 1) == 1;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
